mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage controller between the EX/MEM pipeline register and dataMem (32x32, word-addressed, registered read).
//   Accepts one load/store per handshake and translates byte addresses into word accesses.
//   Handles byte/half/word sizes, doing sub-word stores as read-modify-write, since dataMem has no byte enables.
//   Returns load results to the MEM/WB register with a valid strobe; stalls upstream via req_ready.
// PARAMETERS
//   ADDR_BITS   5   dataMem word-address width; byte-address bits above ADDR_BITS+1 are ignored (wrap)
//   DATA_W      32  datapath width; only 32 is supported
// PORTS
//   CLK            in   1   clock; all state updates on posedge
//   RST            in   1   synchronous, active-high reset
//   req_valid      in   1   request present from EX/MEM
//   req_ready      out  1   unit idle; request accepted on posedge when req_valid&req_ready
//   req_load       in   1   1=load, 0=store
//   req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_signed     in   1   load: 1=sign-extend, 0=zero-extend; ignored for stores
//   req_addr       in   32  byte address
//   req_wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   req_rd         in   5   load destination register, passed to wb_rd
//   wb_valid       out  1   one-cycle strobe: wb_data/wb_rd valid (loads only)
//   wb_data        out  32  extended load result
//   wb_rd          out  5   destination register of the completed load
//   misalign       out  1   one-cycle error strobe for a misaligned or illegal-size request
//   dm_address     out  ADDR_BITS  word address = captured addr[ADDR_BITS+1:2]
//   dm_memRead     out  1   dataMem read enable
//   dm_memWrite    out  1   dataMem write enable; never high together with dm_memRead
//   dm_writeData   out  32  dataMem write data
//   dm_readData    in   32  dataMem output, valid the cycle after dm_memRead
// BEHAVIOUR
//   Reset: state=IDLE; wb_valid, wb_data, wb_rd and misalign are 0.
//     dm_memRead and dm_memWrite are gated by !RST, so no memory access happens on a reset edge.
//     Reset mid-operation abandons the request; a pending RMW write is not performed.
//   States: IDLE, RD, EXT, WR. req_ready=1 only in IDLE. Request fields are captured on acceptance.
//   Accept edge: if word with addr[1:0]!=0, half with addr[0]=1, or size=11:
//     misalign=1 for the next cycle; no memory access; no wb_valid; stay in IDLE.
//   Otherwise:
//     load                  -> RD
//     word store            -> WR
//     byte/half store       -> RD
//   RD:  dm_memRead=1, dm_address=word index. Next state: EXT for loads, WR for stores.
//   EXT: select lane from dm_readData and extend. On the next edge: wb_data/wb_rd load, wb_valid=1, next state IDLE.
//   WR:  dm_memWrite=1.
//     Word store: dm_writeData=wdata.
//     Sub-word store: dm_writeData = dm_readData with the addressed lane replaced by wdata. Next state IDLE.
//   Lanes are little-endian:
//     byte k   = bits [8k+7:8k], k=addr[1:0]
//     half h   = bits [16h+15:16h], h=addr[1]
//   Latency from accept edge:
//     load: wb_valid high during the 3rd cycle
//     word store: 1 cycle busy
//     sub-word store: 2 cycles busy
//   wb_valid and misalign are single-cycle. Both may coincide with req_ready=1 (IDLE); a new accept that cycle is legal.
//   wb_rd=0 loads still raise wb_valid; writeback ignores r0.
// TESTING
//   1 Word store 0x12345678 @0x08, then word load @0x08 -> dm_address=2; wb_data=0x12345678, wb_valid 3 cycles after accept.
//   2 Byte store 0xAB @0x09 -> word=0x1234AB78; signed byte load @0x09 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
//   3 Half store 0x8001 @0x0A -> word=0x8001AB78; signed half load @0x0A -> 0xFFFF8001; unsigned -> 0x00008001.
//   4 Word load @0x06 -> misalign one cycle; no dm_memRead; no wb_valid; memory unchanged; req_ready stays 1.
//   5 req_valid held with two loads -> req_ready low in RD/EXT; second load accepted in the IDLE cycle where the first shows wb_valid; both results correct.
//   6 RST high during WR of byte store @0x09 -> dm_memWrite=0 at that edge; word unchanged; all outputs 0; state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a word-addressed, registered-read dataMem.
// Sub-word stores are done as read-modify-write because the memory has no byte enables.
module mem_access_unit #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_load,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 wb_valid,
    output logic [DATA_W-1:0]    wb_data,
    output logic [4:0]           wb_rd,
    output logic                 misalign,
    output logic [ADDR_BITS-1:0] dm_address,
    output logic                 dm_memRead,
    output logic                 dm_memWrite,
    output logic [DATA_W-1:0]    dm_writeData,
    input  logic [DATA_W-1:0]    dm_readData
);

    typedef enum logic [1:0] {IDLE, RD, EXT, WR} state_t;

    state_t stateReg, stateNext;

    logic                 loadReg;
    logic [1:0]           sizeReg;
    logic                 signedReg;
    logic [ADDR_BITS+1:0] addrReg;
    logic [DATA_W-1:0]    wdataReg;
    logic [4:0]           rdReg;

    logic              accept;
    logic              badReq;
    logic [DATA_W-1:0] shiftedData;
    logic [7:0]        byteLane;
    logic [15:0]       halfLane;
    logic [DATA_W-1:0] loadResult;
    logic [DATA_W-1:0] mergeData;
    logic              unusedAddr;

    // Address bits above the memory's reach simply wrap.
    assign unusedAddr = ^req_addr[31:ADDR_BITS+2];

    assign accept = req_valid && req_ready;

    always_comb begin
        badReq = 1'b0;
        case (req_size)
            2'b01:   badReq = req_addr[0];
            2'b10:   badReq = (req_addr[1:0] != 2'b00);
            2'b11:   badReq = 1'b1;
            default: badReq = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (accept && !badReq) begin
                    if (!req_load && req_size == 2'b10) begin
                        stateNext = WR;
                    end else begin
                        stateNext = RD;
                    end
                end
            end
            RD:      stateNext = loadReg ? EXT : WR;
            EXT:     stateNext = IDLE;
            WR:      stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            loadReg   <= 1'b0;
            sizeReg   <= 2'b00;
            signedReg <= 1'b0;
            addrReg   <= '0;
            wdataReg  <= '0;
            rdReg     <= 5'd0;
        end else if (accept) begin
            loadReg   <= req_load;
            sizeReg   <= req_size;
            signedReg <= req_signed;
            addrReg   <= req_addr[ADDR_BITS+1:0];
            wdataReg  <= req_wdata;
            rdReg     <= req_rd;
        end
    end

    // Little-endian lane selection and extension of the memory word.
    assign shiftedData = dm_readData >> {addrReg[1:0], 3'b000};
    assign byteLane    = shiftedData[7:0];
    assign halfLane    = addrReg[1] ? dm_readData[31:16] : dm_readData[15:0];

    always_comb begin
        case (sizeReg)
            2'b00:   loadResult = {{(DATA_W-8){signedReg & byteLane[7]}}, byteLane};
            2'b01:   loadResult = {{(DATA_W-16){signedReg & halfLane[15]}}, halfLane};
            default: loadResult = dm_readData;
        endcase
    end

    // Per-byte merge of store data into the word read back during RD.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       hitLane;
        logic [7:0] srcByte;
        logic       halfHit;

        assign halfHit = (gi >= 2) ? addrReg[1] : !addrReg[1];
        assign hitLane = ((sizeReg == 2'b00) && (addrReg[1:0] == 2'(gi)))
                      || ((sizeReg == 2'b01) && halfHit);
        if (gi % 2 == 1) begin : g_odd
            assign srcByte = sizeReg[0] ? wdataReg[15:8] : wdataReg[7:0];
        end else begin : g_even
            assign srcByte = wdataReg[7:0];
        end
        assign mergeData[8*gi +: 8] = hitLane ? srcByte : dm_readData[8*gi +: 8];
    end

    always_comb begin
        req_ready    = (stateReg == IDLE);
        dm_address   = addrReg[ADDR_BITS+1:2];
        dm_memRead   = (stateReg == RD) && !RST;
        dm_memWrite  = (stateReg == WR) && !RST;
        dm_writeData = (sizeReg == 2'b10) ? wdataReg : mergeData;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= 5'd0;
            misalign <= 1'b0;
        end else begin
            wb_valid <= (stateReg == EXT);
            misalign <= accept && badReq;
            if (stateReg == EXT) begin
                wb_data <= loadResult;
                wb_rd   <= rdReg;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32x32 registered-read dataMem.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_load = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign;
    logic [4:0]  dm_address;
    logic        dm_memRead;
    logic        dm_memWrite;
    logic [31:0] dm_writeData;
    logic [31:0] dm_readData = 32'd0;

    logic [31:0] mem [32];

    int total = 0;
    int bad = 0;

    mem_access_unit #(.ADDR_BITS(5), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .misalign(misalign),
        .dm_address(dm_address), .dm_memRead(dm_memRead), .dm_memWrite(dm_memWrite),
        .dm_writeData(dm_writeData), .dm_readData(dm_readData)
    );

    always #5 CLK = ~CLK;

    // Read output only changes when a read is performed.
    always @(posedge CLK) begin
        if (dm_memWrite) mem[dm_address] <= dm_writeData;
        if (dm_memRead)  dm_readData <= mem[dm_address];
    end

    // Presents one request for a single accept edge; returns #1 after that edge.
    task automatic issue(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        @(negedge CLK);
        req_valid = 1'b1; req_load = ld; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           input logic [4:0] rd, output logic vld, output logic [31:0] data,
                           output logic [4:0] rdo);
        issue(1'b1, sz, sg, a, 32'd0, rd);
        repeat (3) @(negedge CLK);
        vld = wb_valid; data = wb_data; rdo = wb_rd;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        total++;
        if (dm_memRead !== 1'b0 || dm_memWrite !== 1'b0) begin
            bad++; $display("FAIL reset_dm: rd=%b wr=%b required 0 0", dm_memRead, dm_memWrite);
        end
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({wb_valid, misalign, wb_data, wb_rd, req_ready} !== {1'b0, 1'b0, 32'd0, 5'd0, 1'b1}) begin
            bad++; $display("FAIL reset_out: wbv=%b mis=%b data=%h rd=%0d ready=%b required 0 0 0 0 1",
                            wb_valid, misalign, wb_data, wb_rd, req_ready);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_word;
        logic v; logic [31:0] d; logic [4:0] r;
        issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h12345678, 5'd0);
        @(negedge CLK);
        total++;
        if (dm_memWrite !== 1'b1 || dm_memRead !== 1'b0 || dm_address !== 5'd2 || dm_writeData !== 32'h12345678) begin
            bad++; $display("FAIL word_store_wr: wr=%b rd=%b addr=%0d wdata=%h required 1 0 2 12345678",
                            dm_memWrite, dm_memRead, dm_address, dm_writeData);
        end
        @(negedge CLK);
        total++;
        if (mem[2] !== 32'h12345678 || req_ready !== 1'b1) begin
            bad++; $display("FAIL word_store_mem: mem=%h ready=%b required 12345678 1", mem[2], req_ready);
        end
        issue(1'b1, 2'b10, 1'b0, 32'h08, 32'd0, 5'd7);
        @(negedge CLK);
        total++;
        if (dm_memRead !== 1'b1 || dm_address !== 5'd2 || req_ready !== 1'b0) begin
            bad++; $display("FAIL word_load_rd: rd=%b addr=%0d ready=%b required 1 2 0",
                            dm_memRead, dm_address, req_ready);
        end
        @(negedge CLK);
        total++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL word_load_early: wbv=%b ready=%b required 0 0", wb_valid, req_ready);
        end
        @(negedge CLK);
        v = wb_valid; d = wb_data; r = wb_rd;
        total++;
        if (v !== 1'b1 || d !== 32'h12345678 || r !== 5'd7) begin
            bad++; $display("FAIL word_load: wbv=%b data=%h rd=%0d required 1 12345678 7", v, d, r);
        end
        @(negedge CLK);
        total++;
        if (wb_valid !== 1'b0) begin
            bad++; $display("FAIL word_load_strobe: wbv=%b required 0", wb_valid);
        end
        $display("word store/load @08: data=%h", d);
    endtask

    task automatic test_byte;
        logic v; logic [31:0] d; logic [4:0] r;
        issue(1'b0, 2'b00, 1'b0, 32'h09, 32'hFFFFFFAB, 5'd0);
        @(negedge CLK);
        total++;
        if (dm_memRead !== 1'b1 || dm_memWrite !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL byte_store_rd: rd=%b wr=%b ready=%b required 1 0 0", dm_memRead, dm_memWrite, req_ready);
        end
        @(negedge CLK);
        total++;
        if (dm_memWrite !== 1'b1 || dm_writeData !== 32'h1234AB78) begin
            bad++; $display("FAIL byte_store_wr: wr=%b wdata=%h required 1 1234ab78", dm_memWrite, dm_writeData);
        end
        @(negedge CLK);
        total++;
        if (mem[2] !== 32'h1234AB78 || req_ready !== 1'b1) begin
            bad++; $display("FAIL byte_store_mem: mem=%h ready=%b required 1234ab78 1", mem[2], req_ready);
        end
        do_load(2'b00, 1'b1, 32'h09, 5'd5, v, d, r);
        total++;
        if (v !== 1'b1 || d !== 32'hFFFFFFAB || r !== 5'd5) begin
            bad++; $display("FAIL byte_load_s: wbv=%b data=%h rd=%0d required 1 ffffffab 5", v, d, r);
        end
        do_load(2'b00, 1'b0, 32'h09, 5'd6, v, d, r);
        total++;
        if (v !== 1'b1 || d !== 32'h000000AB) begin
            bad++; $display("FAIL byte_load_u: wbv=%b data=%h required 1 000000ab", v, d);
        end
        do_load(2'b00, 1'b1, 32'h0B, 5'd0, v, d, r);
        total++;
        if (v !== 1'b1 || d !== 32'h00000012 || r !== 5'd0) begin
            bad++; $display("FAIL byte_load_lane3: wbv=%b data=%h rd=%0d required 1 00000012 0", v, d, r);
        end
        $display("byte store/load @09: last data=%h", d);
    endtask

    task automatic test_half;
        logic v; logic [31:0] d; logic [4:0] r;
        issue(1'b0, 2'b01, 1'b0, 32'h0A, 32'h00008001, 5'd0);
        repeat (3) @(negedge CLK);
        total++;
        if (mem[2] !== 32'h8001AB78) begin
            bad++; $display("FAIL half_store_mem: mem=%h required 8001ab78", mem[2]);
        end
        do_load(2'b01, 1'b1, 32'h0A, 5'd9, v, d, r);
        total++;
        if (v !== 1'b1 || d !== 32'hFFFF8001) begin
            bad++; $display("FAIL half_load_s: wbv=%b data=%h required 1 ffff8001", v, d);
        end
        do_load(2'b01, 1'b0, 32'h0A, 5'd9, v, d, r);
        total++;
        if (v !== 1'b1 || d !== 32'h00008001) begin
            bad++; $display("FAIL half_load_u: wbv=%b data=%h required 1 00008001", v, d);
        end
        do_load(2'b01, 1'b1, 32'h08, 5'd9, v, d, r);
        total++;
        if (v !== 1'b1 || d !== 32'hFFFFAB78) begin
            bad++; $display("FAIL half_load_low: wbv=%b data=%h required 1 ffffab78", v, d);
        end
        $display("half store/load @0A: last data=%h", d);
    endtask

    task automatic test_misalign;
        logic [31:0] snap;
        snap = mem[1];
        issue(1'b1, 2'b10, 1'b0, 32'h06, 32'd0, 5'd3);
        @(negedge CLK);
        total++;
        if (misalign !== 1'b1 || dm_memRead !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL misalign_strobe: mis=%b rd=%b ready=%b required 1 0 1", misalign, dm_memRead, req_ready);
        end
        repeat (2) @(negedge CLK);
        total++;
        if (misalign !== 1'b0 || wb_valid !== 1'b0 || dm_memRead !== 1'b0 || mem[1] !== snap) begin
            bad++; $display("FAIL misalign_after: mis=%b wbv=%b rd=%b mem=%h required 0 0 0 %h",
                            misalign, wb_valid, dm_memRead, mem[1], snap);
        end
        issue(1'b0, 2'b11, 1'b0, 32'h08, 32'hDEADBEEF, 5'd0);
        @(negedge CLK);
        total++;
        if (misalign !== 1'b1 || dm_memWrite !== 1'b0 || dm_memRead !== 1'b0) begin
            bad++; $display("FAIL illegal_size: mis=%b wr=%b rd=%b required 1 0 0", misalign, dm_memWrite, dm_memRead);
        end
        @(negedge CLK);
        total++;
        if (mem[2] !== 32'h8001AB78 || dm_memWrite !== 1'b0) begin
            bad++; $display("FAIL illegal_size_mem: mem=%h wr=%b required 8001ab78 0", mem[2], dm_memWrite);
        end
        $display("misalign word load @06 and illegal size store: checked");
    endtask

    task automatic test_back_to_back;
        @(negedge CLK);
        req_valid = 1'b1; req_load = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h08; req_rd = 5'd3;
        @(posedge CLK);
        #1 req_size = 2'b00; req_addr = 32'h09; req_rd = 5'd4;
        @(negedge CLK);
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_ready_rd: ready=%b required 0", req_ready);
        end
        @(negedge CLK);
        total++;
        if (req_ready !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_ready_ext: ready=%b wbv=%b required 0 0", req_ready, wb_valid);
        end
        @(negedge CLK);
        total++;
        if (req_ready !== 1'b1 || wb_valid !== 1'b1 || wb_data !== 32'h8001AB78 || wb_rd !== 5'd3) begin
            bad++; $display("FAIL b2b_first: ready=%b wbv=%b data=%h rd=%0d required 1 1 8001ab78 3",
                            req_ready, wb_valid, wb_data, wb_rd);
        end
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        total++;
        if (dm_memRead !== 1'b1 || req_ready !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_second_accept: rd=%b ready=%b wbv=%b required 1 0 0", dm_memRead, req_ready, wb_valid);
        end
        repeat (2) @(negedge CLK);
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h000000AB || wb_rd !== 5'd4) begin
            bad++; $display("FAIL b2b_second: wbv=%b data=%h rd=%0d required 1 000000ab 4", wb_valid, wb_data, wb_rd);
        end
        $display("back-to-back loads: second data=%h", wb_data);
    endtask

    task automatic test_reset_midop;
        issue(1'b0, 2'b00, 1'b0, 32'h09, 32'h00000055, 5'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        total++;
        if (dm_memWrite !== 1'b0) begin
            bad++; $display("FAIL rst_gate_write: wr=%b required 0", dm_memWrite);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        total++;
        if (mem[2] !== 32'h8001AB78) begin
            bad++; $display("FAIL rst_mem: mem=%h required 8001ab78", mem[2]);
        end
        total++;
        if ({req_ready, wb_valid, misalign, wb_data, wb_rd, dm_memRead, dm_memWrite}
            !== {1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rst_outputs: ready=%b wbv=%b mis=%b data=%h rd=%0d dmr=%b dmw=%b required 1 0 0 0 0 0 0",
                            req_ready, wb_valid, misalign, wb_data, wb_rd, dm_memRead, dm_memWrite);
        end
        $display("reset during byte store write: mem=%h", mem[2]);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
